// File: rtl/note_sequencer.sv
// Note sequencer: steps a small pattern memory and drives divide/gate.
// Define NOTE_SEQUENCER_LOOP_EN to wrap to step 0 at pattern end.
module note_sequencer #(
    parameter int N  = 8,
    parameter int AW = 4,
    parameter int TW = 20,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic [TW-1:0] tick_period,
    input  logic [AW:0]   len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_divide,
    input  logic [DW-1:0] wr_dur,
    input  logic          wr_rest,
    output logic [N-1:0]  divide,
    output logic          gate,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          done
);
    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSED
    } state_e;

    state_e state_q, state_d;

    logic [N-1:0]  mem_div  [DEPTH];
    logic [DW-1:0] mem_dur  [DEPTH];
    logic          mem_rest [DEPTH];

    logic [AW-1:0] step_q, step_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [N-1:0]  div_q, div_d;
    logic          rest_q, rest_d;
    logic          done_q, done_d;

    logic [AW:0]   len_c;
    logic [DW-1:0] dur_last;
    logic          tick, step_end, last_step;
    logic          start_ok, pat_end, load;
    logic [AW-1:0] ld_addr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_div[wr_addr]  <= wr_divide;
            mem_dur[wr_addr]  <= wr_dur;
            mem_rest[wr_addr] <= wr_rest;
        end
    end

    always_comb begin
        len_c     = (len > LEN_MAX) ? LEN_MAX : len;
        dur_last  = (dur_q == '0) ? '0 : dur_q - 1'b1;
        tick      = (state_q == S_PLAY) && (tick_q >= tick_period);
        step_end  = tick && (dcnt_q == dur_last);
        last_step = ({1'b0, step_q} + 1'b1) >= len_c;
        start_ok  = (state_q == S_IDLE) && start && (len != '0) && !stop;
        pat_end   = step_end && last_step && !stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (stop) state_d = S_IDLE;
`ifndef NOTE_SEQUENCER_LOOP_EN
                else if (pat_end) state_d = S_IDLE;
`endif
                else if (pause) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (stop) state_d = S_IDLE;
                else if (!pause) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The loaded entry is snapshotted, so a same-edge write is seen next load.
    always_comb begin
`ifdef NOTE_SEQUENCER_LOOP_EN
        load = start_ok || (step_end && !stop);
`else
        load = start_ok || (step_end && !stop && !last_step);
`endif
        ld_addr = (start_ok || last_step) ? '0 : step_q + 1'b1;
        step_d  = step_q;
        tick_d  = tick_q;
        dcnt_d  = dcnt_q;
        dur_d   = dur_q;
        div_d   = div_q;
        rest_d  = rest_q;
        done_d  = pat_end;
        if (start_ok) begin
            tick_d = '0;
            dcnt_d = '0;
        end else if (state_q == S_PLAY) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
            if (step_end) dcnt_d = '0;
            else if (tick) dcnt_d = dcnt_q + 1'b1;
        end
        if (load) begin
            step_d = ld_addr;
            dur_d  = mem_dur[ld_addr];
            rest_d = mem_rest[ld_addr];
            if (!mem_rest[ld_addr]) div_d = mem_div[ld_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            tick_q <= '0;
            dcnt_q <= '0;
            dur_q  <= '0;
            div_q  <= '0;
            rest_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            step_q <= step_d;
            tick_q <= tick_d;
            dcnt_q <= dcnt_d;
            dur_q  <= dur_d;
            div_q  <= div_d;
            rest_q <= rest_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        gate   = (state_q == S_PLAY) && !rest_q;
        divide = div_q;
        step   = step_q;
        done   = done_q;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed and random playback compared against
// a per-cycle trace expanded from the pattern table.
module tb_note_sequencer;
    localparam int N     = 8;
    localparam int AW    = 4;
    localparam int TW    = 20;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef NOTE_SEQUENCER_LOOP_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, start, stop, pause;
    logic [TW-1:0] tick_period;
    logic [AW:0]   len;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_divide;
    logic [DW-1:0] wr_dur;
    logic          wr_rest;
    logic [N-1:0]  divide;
    logic          gate;
    logic [AW-1:0] step;
    logic          busy, done;

    note_sequencer #(.N(N), .AW(AW), .TW(TW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .tick_period(tick_period), .len(len), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_divide(wr_divide), .wr_dur(wr_dur),
        .wr_rest(wr_rest), .divide(divide), .gate(gate), .step(step),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dv;
        bit g;
        int st;
        bit b;
        bit d;
        bit ds;
    } exp_t;

    int   m_div [DEPTH];
    int   m_dur [DEPTH];
    bit   m_rest[DEPTH];
    int   m_last;
    exp_t tr[$];
    int   n_tot = 0;
    int   n_ok  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tot++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int dv, input int du, input bit r);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_divide = N'(dv);
        wr_dur = DW'(du);
        wr_rest = r;
        cyc();
        wr_en = 1'b0;
        m_div[a] = dv;
        m_dur[a] = du;
        m_rest[a] = r;
    endtask

    // Each step lasts max(dur,1)*(tp+1) cycles; a write at edge wi is seen
    // only by steps loaded at a later edge.
    function automatic void build(input int tp, input int ln,
                                  input int wi, input int wa, input int wd);
        int lc;
        int dv;
        exp_t e;
        lc = (ln > DEPTH) ? DEPTH : ln;
        dv = m_last;
        tr.delete();
        for (int p = 0; p < NPASS; p++) begin
            for (int s = 0; s < lc; s++) begin
                int d;
                d = (m_dur[s] == 0) ? 1 : m_dur[s];
                if (!m_rest[s])
                    dv = (wi >= 0 && s == wa && tr.size() > wi) ? wd : m_div[s];
                for (int c = 0; c < d * (tp + 1); c++) begin
                    e.dv = dv; e.g = !m_rest[s]; e.st = s;
                    e.b = 1'b1; e.d = (p > 0 && s == 0 && c == 0); e.ds = 1'b1;
                    tr.push_back(e);
                end
            end
        end
        if (NPASS == 1) begin
            e = tr[tr.size()-1];
            e.g = 1'b0; e.b = 1'b0; e.d = 1'b1;
            tr.push_back(e);
        end
    endfunction

    function automatic int nbusy();
        int n = 0;
        while (n < tr.size() && tr[n].b) n++;
        return n;
    endfunction

    // pa<0: random pause; sa=-2: random stop; smode 1/2: stray starts while busy
    task automatic play(input string tag, input int tp, input int ln,
                        input int pa_i, input int pp_i, input int sa_i,
                        input int wi, input int wa, input int wd, input int smode);
        exp_t e, q;
        int pa, pp, sa, nb;
        build(tp, ln, wi, wa, wd);
        pa = pa_i; pp = pp_i; sa = sa_i;
        if (pa < 0) begin
            nb = nbusy();
            pa = (nb >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, nb - 1)) : 0;
            pp = int'($urandom_range(1, 6));
        end
        if (pa > 0) begin
            e = tr[pa];
            tr[pa].d = 1'b0;
            for (int k = 0; k < pp; k++) begin
                q = e; q.g = 1'b0; q.d = (k == 0) ? e.d : 1'b0;
                tr.insert(pa + k, q);
            end
        end
        nb = nbusy();
        if (sa == -2) sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb)) : -1;
        if (sa == -1 && NPASS > 1) sa = nb;
        if (sa > 0) begin
            q = tr[sa-1];
            while (tr.size() > sa) void'(tr.pop_back());
            q.g = 1'b0; q.b = 1'b0; q.d = 1'b0; q.ds = 1'b0;
            tr.push_back(q);
        end
        tick_period = TW'(tp);
        len = (AW+1)'(ln);
        foreach (tr[i]) begin
            start = (i == 0) || (i > 0 && tr[i-1].b &&
                    (smode == 1 || (smode == 2 && $urandom_range(0, 3) == 0)));
            pause = (pa > 0 && i >= pa && i < pa + pp);
            stop = (i == sa);
            wr_en = (i == wi);
            wr_addr = AW'(wa);
            wr_divide = N'(wd);
            wr_dur = DW'(m_dur[wa]);
            wr_rest = m_rest[wa];
            cyc();
            check({tag, ".gate"}, int'(gate), int'(tr[i].g));
            check({tag, ".busy"}, int'(busy), int'(tr[i].b));
            check({tag, ".done"}, int'(done), int'(tr[i].d));
            if (tr[i].ds) begin
                check({tag, ".divide"}, int'(divide), tr[i].dv);
                check({tag, ".step"}, int'(step), tr[i].st);
            end
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0; wr_en = 1'b0;
        if (wi >= 0) m_div[wa] = wd;
        m_last = tr[tr.size()-1].dv;
        repeat (2) begin
            cyc();
            check({tag, ".idle_busy"}, int'(busy), 0);
            check({tag, ".idle_gate"}, int'(gate), 0);
            check({tag, ".idle_done"}, int'(done), 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".divide"}, int'(divide), 0);
        check({tag, ".gate"}, int'(gate), 0);
        check({tag, ".step"}, int'(step), 0);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        tick_period = '0; len = '0; wr_en = 1'b0; wr_addr = '0;
        wr_divide = '0; wr_dur = '0; wr_rest = 1'b0;
        m_last = 0;
        for (int a = 0; a < DEPTH; a++) begin
            m_div[a] = 0; m_dur[a] = 0; m_rest[a] = 1'b0;
        end
        repeat (2) cyc();
        check_zero("reset");
        rst = 1'b0;

        wr(0, 4, 2, 1'b0);
        wr(1, 9, 1, 1'b0);
        play("basic", 3, 2, 0, 0, -1, -1, 0, 0, 0);

        wr(1, 7, 0, 1'b1);
        play("rest", 1, 2, 0, 0, -1, -1, 0, 0, 0);

        wr(0, 5, 3, 1'b0);
        play("pause", 1, 1, 3, 5, -1, -1, 0, 0, 0);

        wr(0, 6, 1, 1'b0);
        wr(1, 11, 3, 1'b0);
        play("stop", 1, 2, 0, 0, 4, -1, 0, 0, 1);

        len = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("len0.busy", int'(busy), 0);
        cyc();
        check("len0.busy2", int'(busy), 0);
        check("len0.gate", int'(gate), 0);

        wr(0, 3, 1, 1'b0);
        wr(1, 8, 2, 1'b0);
        play("collide", 2, 2, 0, 0, -1, 3, 1, 20, 0);
        play("replay", 2, 2, 0, 0, -1, -1, 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < DEPTH; a++)
                wr(a, int'($urandom_range(1, 255)), int'($urandom_range(0, 3)),
                   (a != 0) && ($urandom_range(0, 3) == 0));
            play("rnd", int'($urandom_range(0, 3)), int'($urandom_range(1, 20)),
                 -1, 0, -2, -1, 0, 0, 2);
        end

        wr(0, 13, 2, 1'b0);
        wr(1, 17, 1, 1'b0);
        tick_period = TW'(2);
        len = (AW+1)'(2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        check_zero("midrst");
        rst = 1'b0;
        m_last = 0;
        play("postrst", 2, 2, 0, 0, -1, -1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

endmodule
